ahb_lite_master: RTL and testbench

- Initiator end of the AHB-side link. Accepts single read/write commands from a local requester over a valid/ready interface.
- Drives hsel/haddr/hwrite/hready/hwdata towards the AHB-to-peripheral bridge, waits for hreadyout, samples hresp/hrdata, and returns one response per command.
- Used by the CPU-side test harness and DMA stubs to exercise the bridge.

---
 rtl/ahb_master_pkg.sv | 16 +
 rtl/ahb_wait_timer.sv | 36 +++
 rtl/ahb_lite_master.sv | 173 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_pkg.sv
// Shared types and constants for the AHB-Lite initiator: FSM encoding, default widths.
package ahb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int XFER_CNT_W = 16;
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/ahb_wait_timer.sv
// Data-phase wait counter: clear, count enabled wait cycles, flag the limit-th wait.
// expired_o is combinational on en_i so the caller can leave the data phase in that same cycle.
module ahb_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts waits already taken, so this wait is number cnt_q+1
  assign expired_o = en_i && (cnt_q >= (limit_i - 1'b1));

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: one valid/ready command -> ADDR, DATA (waits on hreadyout), RESP strobe; 3-cycle min latency.
// cmd_ready is high only in IDLE; optional data-phase watchdog under AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  hsel,
  output logic [ADDR_W-1:0]     haddr,
  output logic                  hwrite,
  output logic                  hready,
  output logic [DATA_W-1:0]     hwdata,
  input  logic                  hreadyout,
  input  logic                  hresp,
  input  logic [DATA_W-1:0]     hrdata
);

  localparam logic [WAIT_CNT_W-1:0] TO_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [XFER_CNT_W-1:0]   xfer_count_q, xfer_count_d;
  logic                    hsel_q, hsel_d;
  logic [ADDR_W-1:0]       haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic                    hready_q, hready_d;
  logic [DATA_W-1:0]       hwdata_q, hwdata_d;
  logic                    accept;
  logic                    in_xfer;
  logic                    timeout_hit;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;

`ifdef AHB_MASTER_TIMEOUT_EN
  logic wait_en;
  assign wait_en = (state_q == DATA) && !hreadyout;

  ahb_wait_timer #(
    .CNT_W (WAIT_CNT_W)
  ) u_wait_timer (
    .clk_i     (hclk),
    .rst_i     (hresetn),
    .clr_i     (accept),
    .en_i      (wait_en),
    .limit_i   (TO_LIMIT),
    .expired_o (timeout_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = ^TO_LIMIT;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    xfer_count_d  = xfer_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = ADDR;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (hreadyout) begin
          rsp_err_d     = hresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = write_q ? '0 : hrdata;
          xfer_count_d  = xfer_count_q + 1'b1;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          xfer_count_d  = xfer_count_q + 1'b1;
          state_d       = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    in_xfer     = (state_d == ADDR) || (state_d == DATA);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    hsel_d      = in_xfer;
    hready_d    = in_xfer;
    haddr_d     = in_xfer ? addr_d : '0;
    hwrite_d    = in_xfer && write_d;
    hwdata_d    = ((state_d == DATA) && write_d) ? wdata_d : '0;
  end

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      xfer_count_q  <= '0;
      hsel_q        <= 1'b0;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hready_q      <= 1'b0;
      hwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      xfer_count_q  <= xfer_count_d;
      hsel_q        <= hsel_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hready_q      <= hready_d;
      hwdata_q      <= hwdata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign xfer_count  = xfer_count_q;
  assign hsel        = hsel_q;
  assign haddr       = haddr_q;
  assign hwrite      = hwrite_q;
  assign hready      = hready_q;
  assign hwdata      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed + randomized bench for ahb_lite_master; the bench plays the AHB slave and predicts each cycle.
module tb_ahb_lite_master;

  localparam int TO = 16;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] xfer_count;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout = 1'b0;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] last_rdata = '0;

  ahb_lite_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .xfer_count  (xfer_count),
    .hsel        (hsel),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .hready      (hready),
    .hwdata      (hwdata),
    .hreadyout   (hreadyout),
    .hresp       (hresp),
    .hrdata      (hrdata)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet_bus(input string tag);
    chk({tag, "_hsel"}, hsel, 0);
    chk({tag, "_hready"}, hready, 0);
    chk({tag, "_haddr"}, haddr, 0);
    chk({tag, "_hwrite"}, hwrite, 0);
    chk({tag, "_hwdata"}, hwdata, 0);
  endtask

  task automatic do_reset(input int n);
    hresetn   = 1'b1;
    cmd_valid = 1'b0;
    hreadyout = 1'b0;
    repeat (n) begin
      @(posedge hclk); #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_xfer_count", xfer_count, 0);
      chk_quiet_bus("rst");
    end
    hresetn = 1'b0;
    @(posedge hclk); #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_xfer_count", xfer_count, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_hsel", hsel, 0);
    exp_cnt    = '0;
    last_rdata = '0;
  endtask

  // Cycle 0 = accept cycle. The slave raises hreadyout in DATA cycle wt+1 (cycle wt+2);
  // the response strobe is expected in the cycle right after the last data-phase cycle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int wt,
                      input logic resp, input logic [31:0] rd, input logic hold);
    logic        tmo;
    int          resp_c;
    logic [31:0] exp_rd;
`ifdef AHB_MASTER_TIMEOUT_EN
    tmo = (wt >= TO);
`else
    tmo = 1'b0;
`endif
    resp_c = tmo ? (2 + TO) : (3 + wt);
    exp_rd = (tmo || w) ? 32'h0 : rd;
    chk("accept_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    hrdata    = rd;
    hresp     = resp;
    hreadyout = (wt == 0);
    for (int c = 1; c <= resp_c + 1; c++) begin
      @(posedge hclk); #1;
      if (!hold) cmd_valid = 1'b0;
      if (c < resp_c) begin
        chk("xfer_hsel", hsel, 1);
        chk("xfer_hready", hready, 1);
        chk("xfer_haddr", haddr, a);
        chk("xfer_hwrite", hwrite, w);
        chk("xfer_hwdata", hwdata, (c == 1 || !w) ? 32'h0 : d);
        chk("xfer_rsp_valid", rsp_valid, 0);
        chk("xfer_cmd_ready", cmd_ready, 0);
      end else if (c == resp_c) begin
        exp_cnt    = exp_cnt + 16'd1;
        last_rdata = exp_rd;
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_rsp_err", rsp_err, tmo | resp);
        chk("resp_rsp_timeout", rsp_timeout, tmo);
        chk("resp_rsp_rdata", rsp_rdata, exp_rd);
        chk("resp_xfer_count", xfer_count, exp_cnt);
        chk("resp_cmd_ready", cmd_ready, 0);
        chk_quiet_bus("resp");
      end else begin
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_rsp_rdata_hold", rsp_rdata, last_rdata);
        chk("idle_xfer_count", xfer_count, exp_cnt);
        chk("idle_hsel", hsel, 0);
      end
      hreadyout = (c >= wt + 2) || (wt == 0);
    end
    hreadyout = 1'b0;
  endtask

  initial begin
    logic        rw, rhold, rresp;
    logic [31:0] raddr, rwdata, rrdata;
    int          rwt;

    do_reset(3);

    xfer(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, 32'hAAAA_5555, 1'b0);
    xfer(1'b0, 32'h0000_0080, 32'h0BAD_0BAD, 5, 1'b0, 32'h1234_5678, 1'b0);
    // Held cmd_valid: second identical command must wait for RESP to finish
    xfer(1'b1, 32'h0000_00C0, 32'hCAFE_F00D, 0, 1'b1, 32'h0, 1'b1);
    xfer(1'b1, 32'h0000_00C0, 32'hCAFE_F00D, 0, 1'b1, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h8765_4321, 1'b0);
    xfer(1'b0, 32'h0000_0104, 32'h0, TO - 1, 1'b0, 32'h1111_2222, 1'b0);
    xfer(1'b0, 32'h0000_0108, 32'h0, TO, 1'b0, 32'h3333_4444, 1'b0);
    xfer(1'b1, 32'h0000_010C, 32'h5555_6666, 120, 1'b0, 32'h7777_8888, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rw     = 1'($urandom_range(0, 1));
      rhold  = 1'($urandom_range(0, 1));
      rresp  = ($urandom_range(0, 3) == 0);
      raddr  = $urandom;
      rwdata = $urandom;
      rrdata = $urandom;
      rwt    = $urandom_range(0, 6);
      xfer(rw, raddr, rwdata, rwt, rresp, rrdata, rhold);
    end

    // Reset in the middle of a read's data phase
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0200;
    hreadyout = 1'b0;
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
    @(posedge hclk); #1;
    chk("midrst_pre_hsel", hsel, 1);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    chk("midrst_hsel", hsel, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_xfer_count", xfer_count, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    hresetn = 1'b0;
    @(posedge hclk); #1;
    chk("midrst_rel_cmd_ready", cmd_ready, 1);
    chk("midrst_rel_rsp_valid", rsp_valid, 0);
    exp_cnt    = '0;
    last_rdata = '0;
    xfer(1'b1, 32'h0000_0300, 32'h0102_0304, 2, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
